// File: rtl/oled_pkg.sv
// Shared OLED geometry, RGB565 colour constants and the welcome-sequencer state encoding.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  localparam logic [15:0] BLACK     = 16'h0000;
  localparam logic [15:0] YELLOW    = 16'hFFE0;
  localparam logic [15:0] RED       = 16'hF800;
  localparam logic [15:0] SKY_BLUE  = 16'h867D;
  localparam logic [15:0] BLUSH_RED = 16'hFB2C;

  localparam logic [4:0] ALPHA_FULL = 5'd16;

  typedef enum logic [1:0] {
    WELCOME = 2'd0,
    FADE    = 2'd1,
    MAIN    = 2'd2
  } seq_state_t;

endpackage

// File: rtl/rgb565_blend.sv
// Combinational RGB565 cross-fade: per channel (w*(16-a) + m*a) >> 4, truncated.
module rgb565_blend (
  input  logic [15:0] w,
  input  logic [15:0] m,
  input  logic [4:0]  a,
  output logic [15:0] y
);

  logic [4:0]  a_inv;
  logic [9:0]  r_sum;
  logic [10:0] g_sum;
  logic [9:0]  b_sum;

  assign a_inv = 5'd16 - a;

  assign r_sum = 10'(w[15:11]) * 10'(a_inv) + 10'(m[15:11]) * 10'(a);
  assign g_sum = 11'(w[10:5])  * 11'(a_inv) + 11'(m[10:5])  * 11'(a);
  assign b_sum = 10'(w[4:0])   * 10'(a_inv) + 10'(m[4:0])   * 10'(a);

  // Weights sum to 16, so each shifted sum always fits its channel width.
  assign y = {5'(r_sum >> 4), 6'(g_sum >> 4), 5'(b_sum >> 4)};

endmodule

// File: rtl/welcome_screen_sequencer.sv
// Selects welcome then main pixel stream for the OLED, switching only at frame_begin.
// Define WELCOME_FADE_EN to add the FADE state and cross-fade blend between the two screens.
module welcome_screen_sequencer
  import oled_pkg::*;
#(
  parameter int unsigned WELCOME_FRAMES = 120
`ifdef WELCOME_FADE_EN
  , parameter int unsigned FADE_STEP_FRAMES = 2
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_begin,
  input  logic        skip_pulse,
  input  logic        replay_pulse,
  input  logic [15:0] welcome_pixel,
  input  logic [15:0] main_pixel,
  output logic [15:0] pixel_data,
  output logic        welcome_active,
  output logic [4:0]  fade_alpha
);

  localparam logic [7:0] WELCOME_LAST = 8'(WELCOME_FRAMES - 1);

  seq_state_t  state;
  logic [7:0]  frame_cnt;
  logic        skip_pend;
  logic        replay_pend;
  logic        skip_now;
  logic        replay_now;
  logic [15:0] pixel_next;

`ifdef WELCOME_FADE_EN
  localparam logic [3:0] STEP_LAST = 4'(FADE_STEP_FRAMES - 1);

  logic [3:0]  step_cnt;
  logic [15:0] blend_pixel;

  rgb565_blend u_blend (
    .w (welcome_pixel),
    .m (main_pixel),
    .a (fade_alpha),
    .y (blend_pixel)
  );
`endif

  // A pulse arriving with frame_begin acts at once; skip is meaningless in MAIN, replay outside it.
  assign skip_now   = (skip_pend || skip_pulse) && (state != MAIN);
  assign replay_now = (replay_pend || replay_pulse) && (state == MAIN);

  always_comb begin
    pixel_next = welcome_pixel;
    case (state)
      MAIN: pixel_next = main_pixel;
`ifdef WELCOME_FADE_EN
      FADE: pixel_next = blend_pixel;
`endif
      default: pixel_next = welcome_pixel;
    endcase
  end

  // WELCOME | hold welcome screen   FADE | blend toward main   MAIN | main screen
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= WELCOME;
      frame_cnt      <= 8'd0;
      fade_alpha     <= 5'd0;
      skip_pend      <= 1'b0;
      replay_pend    <= 1'b0;
      pixel_data     <= BLACK;
      welcome_active <= 1'b1;
`ifdef WELCOME_FADE_EN
      step_cnt       <= 4'd0;
`endif
    end else begin
      pixel_data <= pixel_next;

      if (frame_begin) begin
        skip_pend   <= 1'b0;
        replay_pend <= 1'b0;
      end else begin
        if (skip_pulse && state != MAIN)   skip_pend   <= 1'b1;
        if (replay_pulse && state == MAIN) replay_pend <= 1'b1;
      end

      if (frame_begin) begin
        case (state)
          WELCOME: begin
            if (skip_now || frame_cnt == WELCOME_LAST) begin
              frame_cnt <= 8'd0;
`ifdef WELCOME_FADE_EN
              state      <= FADE;
              step_cnt   <= 4'd0;
              fade_alpha <= 5'd0;
`else
              state          <= MAIN;
              welcome_active <= 1'b0;
              fade_alpha     <= ALPHA_FULL;
`endif
            end else begin
              frame_cnt <= frame_cnt + 8'd1;
            end
          end
`ifdef WELCOME_FADE_EN
          FADE: begin
            if (skip_now || fade_alpha == ALPHA_FULL) begin
              state          <= MAIN;
              welcome_active <= 1'b0;
              fade_alpha     <= ALPHA_FULL;
              step_cnt       <= 4'd0;
            end else if (step_cnt == STEP_LAST) begin
              step_cnt   <= 4'd0;
              fade_alpha <= fade_alpha + 5'd1;
            end else begin
              step_cnt <= step_cnt + 4'd1;
            end
          end
`endif
          MAIN: begin
            if (replay_now) begin
              state          <= WELCOME;
              welcome_active <= 1'b1;
              fade_alpha     <= 5'd0;
              frame_cnt      <= 8'd0;
`ifdef WELCOME_FADE_EN
              step_cnt       <= 4'd0;
`endif
            end
          end
          default: begin
            state          <= WELCOME;
            welcome_active <= 1'b1;
            fade_alpha     <= 5'd0;
            frame_cnt      <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_welcome_screen_sequencer.sv
// Randomized and directed bench for welcome_screen_sequencer against a frame-level reference model.
module tb_welcome_screen_sequencer;
  import oled_pkg::*;

  localparam int WF  = 3;
  localparam int FSF = 2;
`ifdef WELCOME_FADE_EN
  localparam bit FADE_EN = 1'b1;
`else
  localparam bit FADE_EN = 1'b0;
`endif
  localparam int MAIN_FB = FADE_EN ? (WF + 16 * FSF + 1) : WF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_begin = 1'b0;
  logic        skip_pulse = 1'b0;
  logic        replay_pulse = 1'b0;
  logic [15:0] welcome_pixel = 16'h0;
  logic [15:0] main_pixel = 16'h0;
  logic [15:0] pixel_data;
  logic        welcome_active;
  logic [4:0]  fade_alpha;

  logic [15:0] wpix = 16'h0;
  logic [15:0] mpix = 16'h0;
  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: mode 0 welcome, 1 fading, 2 main; frame counts per phase.
  int          m_mode = 0;
  int          m_wfr = 0;
  int          m_ffr = 0;
  bit          m_skip = 0;
  bit          m_rep = 0;
  logic [15:0] m_pix = 16'h0;

  welcome_screen_sequencer #(
    .WELCOME_FRAMES(WF)
`ifdef WELCOME_FADE_EN
    , .FADE_STEP_FRAMES(FSF)
`endif
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .frame_begin    (frame_begin),
    .skip_pulse     (skip_pulse),
    .replay_pulse   (replay_pulse),
    .welcome_pixel  (welcome_pixel),
    .main_pixel     (main_pixel),
    .pixel_data     (pixel_data),
    .welcome_active (welcome_active),
    .fade_alpha     (fade_alpha)
  );

  always #5 clock = ~clock;

  function automatic int model_alpha();
    int a;
    if (m_mode == 2) a = 16;
    else if (m_mode == 1) a = (m_ffr / FSF > 16) ? 16 : m_ffr / FSF;
    else a = 0;
    return a;
  endfunction

  function automatic logic [15:0] blend(input logic [15:0] w, input logic [15:0] m, input int a);
    int r, g, b;
    r = (int'(w[15:11]) * (16 - a) + int'(m[15:11]) * a) / 16;
    g = (int'(w[10:5])  * (16 - a) + int'(m[10:5])  * a) / 16;
    b = (int'(w[4:0])   * (16 - a) + int'(m[4:0])   * a) / 16;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  task automatic model_update(input bit fb, input bit sk, input bit rp, input bit rst,
                              input logic [15:0] wp, input logic [15:0] mp);
    bit sk_eff, rp_eff;
    if (rst) begin
      m_mode = 0; m_wfr = 0; m_ffr = 0; m_skip = 0; m_rep = 0; m_pix = 16'h0;
    end else begin
      if (m_mode == 0) m_pix = wp;
      else if (m_mode == 1) m_pix = blend(wp, mp, model_alpha());
      else m_pix = mp;
      sk_eff = (m_skip || sk) && (m_mode != 2);
      rp_eff = (m_rep || rp) && (m_mode == 2);
      if (fb) begin
        m_skip = 0;
        m_rep  = 0;
        if (m_mode == 0) begin
          m_wfr++;
          if (sk_eff || m_wfr == WF) begin
            m_wfr = 0; m_ffr = 0;
            m_mode = FADE_EN ? 1 : 2;
          end
        end else if (m_mode == 1) begin
          if (sk_eff || model_alpha() == 16) m_mode = 2;
          else m_ffr++;
        end else if (rp_eff) begin
          m_mode = 0; m_wfr = 0; m_ffr = 0;
        end
      end else begin
        if (sk && m_mode != 2) m_skip = 1;
        if (rp && m_mode == 2) m_rep = 1;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, and return #1 after the clock edge.
  task automatic step(input bit fb, input bit sk, input bit rp, input bit rst);
    frame_begin = fb; skip_pulse = sk; replay_pulse = rp; reset = rst;
    welcome_pixel = wpix; main_pixel = mpix;
    model_update(fb, sk, rp, rst, wpix, mpix);
    @(posedge clock);
    #1;
    frame_begin = 1'b0; skip_pulse = 1'b0; replay_pulse = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    wpix = BLUSH_RED; mpix = SKY_BLUE;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    tests_run++;
    if (pixel_data !== 16'h0000) begin tests_failed++; $display("FAIL reset_pixel: got %h expected 0000", pixel_data); end
    tests_run++;
    if (welcome_active !== 1'b1) begin tests_failed++; $display("FAIL reset_active: got %b expected 1", welcome_active); end
    tests_run++;
    if (fade_alpha !== 5'd0) begin tests_failed++; $display("FAIL reset_alpha: got %0d expected 0", fade_alpha); end
  endtask

  task automatic test_welcome_to_main();
    wpix = YELLOW; mpix = 16'h001F;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < MAIN_FB + 4; f++) begin
      for (int c = 0; c < 6; c++) begin
        step(c == 0, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if (pixel_data !== m_pix) begin tests_failed++; $display("FAIL w2m_pixel f%0d c%0d: got %h expected %h", f, c, pixel_data, m_pix); end
        tests_run++;
        if (fade_alpha !== 5'(model_alpha())) begin tests_failed++; $display("FAIL w2m_alpha f%0d: got %0d expected %0d", f, fade_alpha, model_alpha()); end
        tests_run++;
        if (welcome_active !== 1'(m_mode != 2)) begin tests_failed++; $display("FAIL w2m_active f%0d: got %b", f, welcome_active); end
        if (f == WF - 2 && c == 5) begin
          tests_run++;
          if (pixel_data !== 16'hFFE0) begin tests_failed++; $display("FAIL w2m_hold: got %h expected FFE0", pixel_data); end
        end
        if (f == MAIN_FB - 2 && c == 5) begin
          tests_run++;
          if (welcome_active !== 1'b1) begin tests_failed++; $display("FAIL w2m_early_main: got %b expected 1", welcome_active); end
        end
        if (f == MAIN_FB - 1 && c == 0) begin
          tests_run++;
          if (welcome_active !== 1'b0) begin tests_failed++; $display("FAIL w2m_main_entry: got %b expected 0", welcome_active); end
        end
      end
    end
    tests_run++;
    if (pixel_data !== 16'h001F) begin tests_failed++; $display("FAIL w2m_final: got %h expected 001F", pixel_data); end
  endtask

  task automatic test_fade_midpoint();
    int i;
    wpix = RED; mpix = 16'h07E0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (i = 0; i < 400; i++) begin
      if (FADE_EN ? (m_mode == 1 && model_alpha() == 8) : (m_mode == 2)) break;
      step((i % 4) == 0, 1'b0, 1'b0, 1'b0);
      tests_run++;
      if (fade_alpha !== 5'(model_alpha())) begin tests_failed++; $display("FAIL mid_alpha_track: got %0d expected %0d", fade_alpha, model_alpha()); end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef WELCOME_FADE_EN
    tests_run++;
    if (fade_alpha !== 5'd8) begin tests_failed++; $display("FAIL mid_alpha: got %0d expected 8", fade_alpha); end
    tests_run++;
    if (pixel_data !== 16'h7BE0) begin tests_failed++; $display("FAIL mid_blend: got %h expected 7BE0", pixel_data); end
`else
    tests_run++;
    if (fade_alpha !== 5'd16) begin tests_failed++; $display("FAIL cut_alpha: got %0d expected 16", fade_alpha); end
    tests_run++;
    if (pixel_data !== 16'h07E0) begin tests_failed++; $display("FAIL cut_pixel: got %h expected 07E0", pixel_data); end
`endif
  endtask

  task automatic test_skip();
    wpix = 16'($urandom); mpix = ~wpix;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    for (int c = 1; c < 20; c++) step(1'b0, c == 10, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'b1 || fade_alpha !== 5'd0) begin
      tests_failed++; $display("FAIL skip_early: active %b alpha %0d, expected 1 and 0", welcome_active, fade_alpha);
    end
    tests_run++;
    if (pixel_data !== wpix) begin tests_failed++; $display("FAIL skip_hold_pixel: got %h expected %h", pixel_data, wpix); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'(!FADE_EN) ^ 1'b0 && welcome_active !== 1'(m_mode != 2)) begin
      tests_failed++; $display("FAIL skip_first_fb: active %b", welcome_active);
    end
    tests_run++;
    if (fade_alpha !== (FADE_EN ? 5'd0 : 5'd16)) begin tests_failed++; $display("FAIL skip_first_alpha: got %0d", fade_alpha); end
    for (int c = 1; c < 20; c++) step(1'b0, c == 5, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'(FADE_EN)) begin tests_failed++; $display("FAIL skip_mid_fade: active %b expected %b", welcome_active, FADE_EN); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'b0 || fade_alpha !== 5'd16) begin
      tests_failed++; $display("FAIL skip_second: active %b alpha %0d, expected 0 and 16", welcome_active, fade_alpha);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (pixel_data !== mpix) begin tests_failed++; $display("FAIL skip_main_pixel: got %h expected %h", pixel_data, mpix); end
  endtask

  task automatic test_skip_coincident();
    wpix = 16'($urandom); mpix = ~wpix;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'(FADE_EN)) begin tests_failed++; $display("FAIL coinc_first: active %b expected %b", welcome_active, FADE_EN); end
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'(FADE_EN)) begin tests_failed++; $display("FAIL coinc_no_leftover: active %b expected %b", welcome_active, FADE_EN); end
    tests_run++;
    if (fade_alpha !== (FADE_EN ? 5'd0 : 5'd16)) begin tests_failed++; $display("FAIL coinc_alpha: got %0d", fade_alpha); end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'b0) begin tests_failed++; $display("FAIL coinc_second: active %b expected 0", welcome_active); end
  endtask

  task automatic test_replay();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'b0) begin tests_failed++; $display("FAIL replay_skip_in_main: active %b expected 0", welcome_active); end
    for (int c = 1; c < 12; c++) step(1'b0, 1'b0, c == 7, 1'b0);
    tests_run++;
    if (welcome_active !== 1'b0) begin tests_failed++; $display("FAIL replay_early: active %b expected 0", welcome_active); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'b1 || fade_alpha !== 5'd0) begin
      tests_failed++; $display("FAIL replay_entry: active %b alpha %0d, expected 1 and 0", welcome_active, fade_alpha);
    end
    wpix = 16'($urandom); mpix = ~wpix;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    tests_run++;
    if (pixel_data !== wpix) begin tests_failed++; $display("FAIL replay_pixel: got %h expected %h", pixel_data, wpix); end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (welcome_active !== 1'b1) begin tests_failed++; $display("FAIL replay_outside_main: active %b expected 1", welcome_active); end
  endtask

  task automatic test_reset_mid_fade();
    int i;
    wpix = 16'($urandom); mpix = 16'($urandom);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (i = 0; i < 400; i++) begin
      if (FADE_EN ? (m_mode == 1 && model_alpha() == 5) : (m_mode == 2)) break;
      step((i % 3) == 0, 1'b0, 1'b0, 1'b0);
    end
    tests_run++;
    if (fade_alpha !== (FADE_EN ? 5'd5 : 5'd16)) begin tests_failed++; $display("FAIL pre_reset_alpha: got %0d", fade_alpha); end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (pixel_data !== 16'h0000 || fade_alpha !== 5'd0 || welcome_active !== 1'b1) begin
      tests_failed++; $display("FAIL mid_reset: pixel %h alpha %0d active %b, expected 0000 0 1", pixel_data, fade_alpha, welcome_active);
    end
  endtask

  task automatic test_random();
    bit fb, sk, rp, rst;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4000; i++) begin
      wpix = 16'($urandom); mpix = 16'($urandom);
      fb  = ($urandom_range(0, 3) == 0);
      sk  = ($urandom_range(0, 29) == 0);
      rp  = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 599) == 0);
      step(fb, sk, rp, rst);
      tests_run++;
      if (pixel_data !== m_pix) begin tests_failed++; $display("FAIL rand_pixel cyc %0d: got %h expected %h", i, pixel_data, m_pix); end
      tests_run++;
      if (fade_alpha !== 5'(model_alpha())) begin tests_failed++; $display("FAIL rand_alpha cyc %0d: got %0d expected %0d", i, fade_alpha, model_alpha()); end
      tests_run++;
      if (welcome_active !== 1'(m_mode != 2)) begin tests_failed++; $display("FAIL rand_active cyc %0d: got %b expected %b", i, welcome_active, m_mode != 2); end
    end
  endtask

  initial begin
    test_reset();
    test_welcome_to_main();
    test_fade_midpoint();
    test_skip();
    test_skip_coincident();
    test_replay();
    test_reset_mid_fade();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
